// File: rtl/decode_stage_pipelined.sv
// Registered instruction decode stage sitting between the instruction cache
// and operand prep. Decodes one instruction per cycle into an ID/EX register
// with valid/ready flow control, load-use hazard bubbles, branch flush and a
// saturating count of the bubbles inserted.
module decode_stage_pipelined #(
    parameter int IW             = 32,
    parameter int RW             = 5,
    parameter int CW             = 4,
    parameter int LOAD_USE_STALL = 1,
    parameter int CNT_W          = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [IW-1:0]    instruction,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [2:0]       opType,
    output logic [CW-1:0]    aluControlCode,
    output logic             unconditionalBranch,
    output logic             branch,
    output logic             memRead,
    output logic             memToReg,
    output logic             memWrite,
    output logic             aluSRC,
    output logic             regWriteFlag,
    output logic [RW-1:0]    readRegister1,
    output logic [RW-1:0]    readRegister2,
    output logic [RW-1:0]    writeRegister,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [2:0] {
        OP_LD = 3'd0,
        OP_CB = 3'd1,
        OP_R  = 3'd2,
        OP_ST = 3'd3,
        OP_I  = 3'd4,
        OP_B  = 3'd5,
        OP_M  = 3'd6
    } op_e;

    op_e             dec_op;
    logic [CW-1:0]   dec_alu;
    logic [RW-1:0]   dec_rr1;
    logic [RW-1:0]   dec_rr2;
    logic [RW-1:0]   dec_wr;
    logic            uses_rr2;
    logic            hazard_raw;
    logic            hazard;
    logic            accept;
    logic            unused_bits;

    op_e             op_q;
    logic [CW-1:0]   alu_q;
    logic            valid_q;
    logic            ub_q;
    logic            br_q;
    logic            mr_q;
    logic            mw_q;
    logic            src_q;
    logic            rw_q;
    logic [RW-1:0]   rr1_q;
    logic [RW-1:0]   rr2_q;
    logic [RW-1:0]   wr_q;
    logic [CNT_W-1:0] cnt_q;

    // Instruction bits that no field of the decode looks at.
    assign unused_bits = ^{instruction[IW-1:31], instruction[21], instruction[15:10]};

    // Classify the incoming instruction; the branch bit outranks everything else.
    always_comb begin
        dec_op = OP_I;
        if (instruction[26])
            dec_op = instruction[29] ? OP_CB : OP_B;
        else if (!instruction[28])
            dec_op = OP_R;
        else if (instruction[23])
            dec_op = OP_M;
        else if (instruction[22])
            dec_op = OP_LD;
        else if (instruction[27])
            dec_op = OP_ST;
        else
            dec_op = OP_I;
    end

    // Select the ALU operation for the decoded class.
    always_comb begin
        dec_alu = '0;
        case (dec_op)
            OP_LD, OP_ST: dec_alu = CW'(2);
            OP_CB:        dec_alu = CW'(7);
            OP_M:         dec_alu = CW'(13);
            OP_R: begin
                if (instruction[24])
                    dec_alu = instruction[30] ? CW'(10) : CW'(2);
                else if (!instruction[29])
                    dec_alu = CW'(6);
                else if (!instruction[30])
                    dec_alu = CW'(4);
                else
                    dec_alu = CW'(9);
            end
            OP_I: begin
                if (instruction[29])
                    dec_alu = CW'(4);
                else if (instruction[30])
                    dec_alu = instruction[25] ? CW'(9) : CW'(10);
                else
                    dec_alu = instruction[25] ? CW'(6) : CW'(2);
            end
            default: dec_alu = '0;
        endcase
    end

    // Register IDs; CB and ST read their second operand from the Rt field.
    always_comb begin
        dec_rr1 = instruction[5 +: RW];
        dec_wr  = instruction[0 +: RW];
        if (dec_op == OP_CB || dec_op == OP_ST)
            dec_rr2 = instruction[0 +: RW];
        else
            dec_rr2 = instruction[16 +: RW];
    end

    // Load-use detection against the load currently held in the ID/EX register.
    always_comb begin
        uses_rr2   = (dec_op == OP_R) || (dec_op == OP_CB) || (dec_op == OP_ST);
        hazard_raw = valid_q && (op_q == OP_LD) && (wr_q != {RW{1'b1}}) && in_valid &&
                     ((dec_rr1 == wr_q) || (uses_rr2 && (dec_rr2 == wr_q)));
    end

    assign hazard   = hazard_raw && (LOAD_USE_STALL != 0);
    assign in_ready = (!valid_q || out_ready) && !hazard && !flush;
    assign accept   = in_valid && in_ready;

    // ID/EX register: flush beats hazard beats load; data only moves on accept.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= 1'b0;
            op_q    <= OP_LD;
            alu_q   <= '0;
            ub_q    <= 1'b0;
            br_q    <= 1'b0;
            mr_q    <= 1'b0;
            mw_q    <= 1'b0;
            src_q   <= 1'b0;
            rw_q    <= 1'b0;
            rr1_q   <= '0;
            rr2_q   <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (hazard) begin
            if (out_ready) begin
                valid_q <= 1'b0;
                if (cnt_q != {CNT_W{1'b1}})
                    cnt_q <= cnt_q + CNT_W'(1);
            end
        end else if (accept) begin
            valid_q <= 1'b1;
            op_q    <= dec_op;
            alu_q   <= dec_alu;
            ub_q    <= (dec_op == OP_B);
            br_q    <= (dec_op == OP_CB);
            mr_q    <= (dec_op == OP_LD);
            mw_q    <= (dec_op == OP_ST);
            src_q   <= !((dec_op == OP_R) || (dec_op == OP_CB));
            rw_q    <= (dec_op == OP_R) || (dec_op == OP_LD) || (dec_op == OP_M);
            rr1_q   <= dec_rr1;
            rr2_q   <= dec_rr2;
            wr_q    <= dec_wr;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid           = valid_q;
    assign opType              = op_q;
    assign aluControlCode      = alu_q;
    assign unconditionalBranch = ub_q;
    assign branch              = br_q;
    assign memRead             = mr_q;
    assign memToReg            = mr_q;
    assign memWrite            = mw_q;
    assign aluSRC              = src_q;
    assign regWriteFlag        = rw_q;
    assign readRegister1       = rr1_q;
    assign readRegister2       = rr2_q;
    assign writeRegister       = wr_q;
    assign stall_count         = cnt_q;

endmodule

// File: tb/tb_decode_stage_pipelined.sv
// Bench for decode_stage_pipelined: three instances share one stimulus stream
// (default, hazard detection off, 2-bit stall counter) and each is compared
// every cycle against its own reference model of the decode stage.
module tb_decode_stage_pipelined;

    localparam logic [31:0] ADD_X1   = 32'h8B030041;
    localparam logic [31:0] LDUR_X1  = 32'hF8400041;
    localparam logic [31:0] ADD_X4   = 32'h8B050024;
    localparam logic [31:0] LDUR_XZR = 32'hF840001F;
    localparam logic [31:0] ADD_X31  = 32'h8B0503E4;
    localparam logic [31:0] STUR_X1  = 32'hF8000041;
    localparam logic [31:0] CBZ_X1   = 32'hB4000001;
    localparam logic [31:0] B_INSN   = 32'h14000000;

    typedef struct packed {
        logic [2:0] op;
        logic [3:0] alu;
        logic       ub;
        logic       br;
        logic       mr;
        logic       mw;
        logic       src;
        logic       rw;
        logic [4:0] rr1;
        logic [4:0] rr2;
        logic [4:0] wr;
    } decoded_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        flush;
    logic        out_ready;
    logic [31:0] instruction;

    logic        readyArr [3];
    logic        validArr [3];
    logic [2:0]  opArr    [3];
    logic [3:0]  aluArr   [3];
    logic        ubArr    [3];
    logic        brArr    [3];
    logic        mrArr    [3];
    logic        m2rArr   [3];
    logic        mwArr    [3];
    logic        srcArr   [3];
    logic        rwArr    [3];
    logic [4:0]  rr1Arr   [3];
    logic [4:0]  rr2Arr   [3];
    logic [4:0]  wrArr    [3];
    logic [15:0] cnt0;
    logic [15:0] cnt1;
    logic [1:0]  cnt2;

    logic        mValid   [3];
    decoded_t    mReg     [3];
    int          mCnt     [3];
    int          cntMax   [3] = '{65535, 65535, 3};
    logic        stallEn  [3] = '{1'b1, 1'b0, 1'b1};
    logic        lastReady[3];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    decode_stage_pipelined dut (
        .clock(clock), .reset(reset), .instruction(instruction), .in_valid(in_valid),
        .in_ready(readyArr[0]), .flush(flush), .out_ready(out_ready), .out_valid(validArr[0]),
        .opType(opArr[0]), .aluControlCode(aluArr[0]), .unconditionalBranch(ubArr[0]),
        .branch(brArr[0]), .memRead(mrArr[0]), .memToReg(m2rArr[0]), .memWrite(mwArr[0]),
        .aluSRC(srcArr[0]), .regWriteFlag(rwArr[0]), .readRegister1(rr1Arr[0]),
        .readRegister2(rr2Arr[0]), .writeRegister(wrArr[0]), .stall_count(cnt0)
    );

    decode_stage_pipelined #(.LOAD_USE_STALL(0)) dutNoStall (
        .clock(clock), .reset(reset), .instruction(instruction), .in_valid(in_valid),
        .in_ready(readyArr[1]), .flush(flush), .out_ready(out_ready), .out_valid(validArr[1]),
        .opType(opArr[1]), .aluControlCode(aluArr[1]), .unconditionalBranch(ubArr[1]),
        .branch(brArr[1]), .memRead(mrArr[1]), .memToReg(m2rArr[1]), .memWrite(mwArr[1]),
        .aluSRC(srcArr[1]), .regWriteFlag(rwArr[1]), .readRegister1(rr1Arr[1]),
        .readRegister2(rr2Arr[1]), .writeRegister(wrArr[1]), .stall_count(cnt1)
    );

    decode_stage_pipelined #(.CNT_W(2)) dutSat (
        .clock(clock), .reset(reset), .instruction(instruction), .in_valid(in_valid),
        .in_ready(readyArr[2]), .flush(flush), .out_ready(out_ready), .out_valid(validArr[2]),
        .opType(opArr[2]), .aluControlCode(aluArr[2]), .unconditionalBranch(ubArr[2]),
        .branch(brArr[2]), .memRead(mrArr[2]), .memToReg(m2rArr[2]), .memWrite(mwArr[2]),
        .aluSRC(srcArr[2]), .regWriteFlag(rwArr[2]), .readRegister1(rr1Arr[2]),
        .readRegister2(rr2Arr[2]), .writeRegister(wrArr[2]), .stall_count(cnt2)
    );

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference decode written straight from the instruction-format rules.
    function automatic decoded_t decodeRef(input logic [31:0] i);
        decoded_t d;
        d = '0;
        if (i[26])       d.op = i[29] ? 3'd1 : 3'd5;
        else if (!i[28]) d.op = 3'd2;
        else if (i[23])  d.op = 3'd6;
        else if (i[22])  d.op = 3'd0;
        else if (i[27])  d.op = 3'd3;
        else             d.op = 3'd4;
        case (d.op)
            3'd0, 3'd3: d.alu = 4'd2;
            3'd1:       d.alu = 4'd7;
            3'd6:       d.alu = 4'd13;
            3'd2: begin
                if (i[24])       d.alu = i[30] ? 4'd10 : 4'd2;
                else if (!i[29]) d.alu = 4'd6;
                else if (!i[30]) d.alu = 4'd4;
                else             d.alu = 4'd9;
            end
            3'd4: begin
                if (i[29])      d.alu = 4'd4;
                else if (i[30]) d.alu = i[25] ? 4'd9 : 4'd10;
                else            d.alu = i[25] ? 4'd6 : 4'd2;
            end
            default: d.alu = 4'd0;
        endcase
        d.src = !(d.op == 3'd2 || d.op == 3'd1);
        d.mr  = (d.op == 3'd0);
        d.mw  = (d.op == 3'd3);
        d.br  = (d.op == 3'd1);
        d.ub  = (d.op == 3'd5);
        d.rw  = (d.op == 3'd2 || d.op == 3'd0 || d.op == 3'd6);
        d.rr1 = i[9:5];
        d.rr2 = (d.op == 3'd1 || d.op == 3'd3) ? i[4:0] : i[20:16];
        d.wr  = i[4:0];
        return d;
    endfunction

    // Compare every output of instance k with its model.
    task automatic checkInstance(input int k);
        logic [31:0] cntGot;
        cntGot = (k == 0) ? {16'b0, cnt0} : (k == 1) ? {16'b0, cnt1} : {30'b0, cnt2};
        checkOutput($sformatf("out_valid[%0d]", k), {31'b0, validArr[k]}, {31'b0, mValid[k]});
        checkOutput($sformatf("opType[%0d]", k), {29'b0, opArr[k]}, {29'b0, mReg[k].op});
        checkOutput($sformatf("alu[%0d]", k), {28'b0, aluArr[k]}, {28'b0, mReg[k].alu});
        checkOutput($sformatf("flags[%0d]", k),
                    {24'b0, ubArr[k], brArr[k], mrArr[k], m2rArr[k], mwArr[k], srcArr[k], rwArr[k], 1'b0},
                    {24'b0, mReg[k].ub, mReg[k].br, mReg[k].mr, mReg[k].mr, mReg[k].mw, mReg[k].src, mReg[k].rw, 1'b0});
        checkOutput($sformatf("regs[%0d]", k), {17'b0, rr1Arr[k], rr2Arr[k], wrArr[k]},
                    {17'b0, mReg[k].rr1, mReg[k].rr2, mReg[k].wr});
        checkOutput($sformatf("stall_count[%0d]", k), cntGot, 32'(mCnt[k]));
    endtask

    // Drive one cycle of inputs, check in_ready before the edge, advance the
    // models on the edge and check the registered outputs just after it.
    task automatic applyStimulus(input logic rst, input logic iv, input logic [31:0] instr,
                                 input logic fl, input logic ordy);
        decoded_t n;
        logic     hz  [3];
        logic     rdy [3];
        @(negedge clock);
        reset       = rst;
        in_valid    = iv;
        instruction = instr;
        flush       = fl;
        out_ready   = ordy;
        #1;
        n = decodeRef(instr);
        for (int k = 0; k < 3; k++) begin
            hz[k] = stallEn[k] && mValid[k] && (mReg[k].op == 3'd0) && (mReg[k].wr != 5'd31) && iv &&
                    ((n.rr1 == mReg[k].wr) ||
                     ((n.op == 3'd2 || n.op == 3'd1 || n.op == 3'd3) && (n.rr2 == mReg[k].wr)));
            rdy[k] = (!mValid[k] || ordy) && !hz[k] && !fl;
            lastReady[k] = readyArr[k];
            checkOutput($sformatf("in_ready[%0d]", k), {31'b0, readyArr[k]}, {31'b0, rdy[k]});
        end
        @(posedge clock);
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                mValid[k] = 1'b0;
                mReg[k]   = '0;
                mCnt[k]   = 0;
            end else if (fl) begin
                mValid[k] = 1'b0;
            end else if (hz[k]) begin
                if (ordy) begin
                    mValid[k] = 1'b0;
                    if (mCnt[k] < cntMax[k]) mCnt[k]++;
                end
            end else if (iv && rdy[k]) begin
                mValid[k] = 1'b1;
                mReg[k]   = n;
            end else if (ordy) begin
                mValid[k] = 1'b0;
            end
        end
        #1;
        for (int k = 0; k < 3; k++) checkInstance(k);
    endtask

    function automatic logic [31:0] randomInstr();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 2) == 0) r[31:21] = 11'h7C2;
        r[4:0]   = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
        r[9:5]   = 5'($urandom_range(0, 3));
        r[20:16] = 5'($urandom_range(0, 3));
        return r;
    endfunction

    initial begin
        reset       = 1'b1;
        in_valid    = 1'b0;
        flush       = 1'b0;
        out_ready   = 1'b1;
        instruction = '0;
        for (int k = 0; k < 3; k++) begin
            mValid[k] = 1'b0;
            mReg[k]   = '0;
            mCnt[k]   = 0;
        end
        repeat (2) @(posedge clock);

        // Reset state and first ADD.
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("reset_valid", {31'b0, validArr[0]}, 32'd0);
        checkOutput("reset_ready", {31'b0, lastReady[0]}, 32'd1);
        applyStimulus(1'b0, 1'b1, ADD_X1, 1'b0, 1'b1);
        checkOutput("add_valid", {31'b0, validArr[0]}, 32'd1);
        checkOutput("add_op", {29'b0, opArr[0]}, 32'd2);
        checkOutput("add_alu", {28'b0, aluArr[0]}, 32'd2);
        checkOutput("add_regs", {17'b0, rr1Arr[0], rr2Arr[0], wrArr[0]}, {17'b0, 5'd2, 5'd3, 5'd1});
        checkOutput("add_rw_src", {30'b0, rwArr[0], srcArr[0]}, 32'b10);

        // Load-use pairs; four bubbles push the 2-bit counter into saturation.
        for (int p = 0; p < 4; p++) begin
            applyStimulus(1'b0, 1'b1, LDUR_X1, 1'b0, 1'b1);
            applyStimulus(1'b0, 1'b1, ADD_X4, 1'b0, 1'b1);
            checkOutput("lu_ready", {31'b0, lastReady[0]}, 32'd0);
            checkOutput("lu_bubble", {31'b0, validArr[0]}, 32'd0);
            checkOutput("lu_count", {16'b0, cnt0}, 32'(p + 1));
            checkOutput("nostall_valid", {31'b0, validArr[1]}, 32'd1);
            applyStimulus(1'b0, 1'b1, ADD_X4, 1'b0, 1'b1);
            checkOutput("lu_add_out", {26'b0, validArr[0], rr1Arr[0]}, {26'b0, 1'b1, 5'd1});
        end
        checkOutput("nostall_count", {16'b0, cnt1}, 32'd0);
        checkOutput("sat_count", {30'b0, cnt2}, 32'd3);

        // Load to XZR never stalls.
        applyStimulus(1'b0, 1'b1, LDUR_XZR, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, ADD_X31, 1'b0, 1'b1);
        checkOutput("xzr_ready", {31'b0, lastReady[0]}, 32'd1);
        checkOutput("xzr_count", {16'b0, cnt0}, 32'd4);

        // Store, conditional branch, unconditional branch.
        applyStimulus(1'b0, 1'b1, STUR_X1, 1'b0, 1'b1);
        checkOutput("stur", {23'b0, opArr[0], rr2Arr[0], mwArr[0]}, {23'b0, 3'd3, 5'd1, 1'b1});
        checkOutput("stur_alu_src", {27'b0, aluArr[0], srcArr[0]}, {27'b0, 4'd2, 1'b1});
        applyStimulus(1'b0, 1'b1, CBZ_X1, 1'b0, 1'b1);
        checkOutput("cbz", {19'b0, opArr[0], brArr[0], aluArr[0], rr2Arr[0]}, {19'b0, 3'd1, 1'b1, 4'd7, 5'd1});
        applyStimulus(1'b0, 1'b1, B_INSN, 1'b0, 1'b1);
        checkOutput("b", {28'b0, opArr[0], ubArr[0]}, {28'b0, 3'd5, 1'b1});

        // Back-pressure holds outputs, then flush drops them.
        applyStimulus(1'b0, 1'b1, ADD_X1, 1'b0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b0, 1'b1, STUR_X1, 1'b0, 1'b0);
            checkOutput("hold_ready", {31'b0, lastReady[0]}, 32'd0);
            checkOutput("hold_op", {28'b0, validArr[0], opArr[0]}, {28'b0, 1'b1, 3'd2});
        end
        applyStimulus(1'b0, 1'b1, STUR_X1, 1'b1, 1'b0);
        checkOutput("flush_valid", {31'b0, validArr[0]}, 32'd0);

        // Reset in the middle of a held hazard stall.
        applyStimulus(1'b0, 1'b1, LDUR_X1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, ADD_X4, 1'b0, 1'b0);
        checkOutput("stall_hold_valid", {31'b0, validArr[0]}, 32'd1);
        applyStimulus(1'b1, 1'b1, ADD_X4, 1'b0, 1'b0);
        checkOutput("rst_outputs", {16'b0, validArr[0], mrArr[0], opArr[0], rr1Arr[0], wrArr[0]}, 32'd0);
        checkOutput("rst_count", {16'b0, cnt0}, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("rst_ready", {31'b0, lastReady[0]}, 32'd1);

        // Randomized traffic against the models.
        for (int c = 0; c < 800; c++) begin
            applyStimulus(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
                          ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                          randomInstr(),
                          ($urandom_range(0, 14) == 0) ? 1'b1 : 1'b0,
                          ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
